// File: rtl/dat_mem_mover_pkg.sv
// Shared constants, state encoding and pointer helper for the dat_mem_mover block-move engine.
package dmove_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } dmove_state_t;

    // Pointers wrap modulo 2**ADDR_W in either direction.
    function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] ptr,
                                                   input logic              backward);
        return backward ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/dat_mem_mover_if.sv
// Bus bundle between the processor/memory side and the dat_mem_mover engine.
interface dat_mem_mover_if #(
    parameter int ADDR_W = dmove_pkg::ADDR_W,
    parameter int DATA_W = dmove_pkg::DATA_W
);

    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr_en;
    logic [DATA_W-1:0] cpu_dat_in;
    logic [DATA_W-1:0] cpu_dat_out;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_dat_in;
    logic [DATA_W-1:0] mem_dat_out;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    // Engine side.
    modport slave (
        input  start, src, dst, len, cpu_addr, cpu_wr_en, cpu_dat_in, mem_dat_out,
        output cpu_dat_out, mem_addr, mem_wr_en, mem_dat_in, busy, done, checksum
    );

    // Processor/memory side.
    modport master (
        output start, src, dst, len, cpu_addr, cpu_wr_en, cpu_dat_in, mem_dat_out,
        input  cpu_dat_out, mem_addr, mem_wr_en, mem_dat_in, busy, done, checksum
    );

endinterface

// File: rtl/dat_mem_mover.sv
// Block-move engine owning the data memory port; memmove-safe copy, processor pass-through when idle.
// Optional running XOR of moved bytes enabled by defining DMOVE_CHECKSUM_EN.
module dat_mem_mover #(
    parameter int ADDR_W = dmove_pkg::ADDR_W,
    parameter int DATA_W = dmove_pkg::DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    dat_mem_mover_if.slave  bus
);

    import dmove_pkg::*;

    dmove_state_t      r_state;
    dmove_state_t      w_next_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_backward;

    logic [ADDR_W-1:0] w_diff;
    logic [ADDR_W-1:0] w_len_m1;
    logic              w_backward;
    logic              w_accept;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_wr_en;
    logic [DATA_W-1:0] w_mem_dat_in;

    // Backward only when the destination starts inside the source window.
    assign w_diff     = bus.dst - bus.src;
    assign w_len_m1   = bus.len - ADDR_W'(1);
    assign w_backward = (w_diff != '0) && (w_diff < bus.len);
    assign w_accept   = (r_state == IDLE) && bus.start;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr  <= '0;
            r_dst_ptr  <= '0;
            r_count    <= '0;
            r_data     <= '0;
            r_backward <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_backward <= w_backward;
                        r_count    <= bus.len;
                        r_src_ptr  <= w_backward ? bus.src + w_len_m1 : bus.src;
                        r_dst_ptr  <= w_backward ? bus.dst + w_len_m1 : bus.dst;
                    end
                end
                READ: begin
                    r_data <= bus.mem_dat_out;
                end
                WRITE: begin
                    r_src_ptr <= step_ptr(r_src_ptr, r_backward);
                    r_dst_ptr <= step_ptr(r_dst_ptr, r_backward);
                    r_count   <= r_count - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_mem_addr   = bus.cpu_addr;
        w_mem_wr_en  = bus.cpu_wr_en;
        w_mem_dat_in = bus.cpu_dat_in;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.len == '0) ? DONE : READ;
                end
            end
            READ: begin
                w_mem_addr   = r_src_ptr;
                w_mem_wr_en  = 1'b0;
                w_next_state = WRITE;
            end
            WRITE: begin
                w_mem_addr   = r_dst_ptr;
                w_mem_wr_en  = 1'b1;
                w_mem_dat_in = r_data;
                w_next_state = (r_count == ADDR_W'(1)) ? DONE : READ;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wr_en   = w_mem_wr_en;
    assign bus.mem_dat_in  = w_mem_dat_in;
    assign bus.cpu_dat_out = bus.mem_dat_out;
    assign bus.busy        = (r_state == READ) || (r_state == WRITE);
    assign bus.done        = (r_state == DONE);

`ifdef DMOVE_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_state == WRITE) begin
            r_checksum <= r_checksum ^ r_data;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_dat_mem_mover.sv
// Directed self-checking bench for dat_mem_mover with a behavioural 256x8 memory beside it.
module tb_dat_mem_mover;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dat_mem_mover_if bus ();

    dat_mem_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: combinational read, write on the rising edge.
    logic [7:0] mem [256];
    assign bus.mem_dat_out = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_in;
    end

    int n_checks   = 0;
    int n_bad      = 0;
    int wr_count   = 0;
    int done_count = 0;

    always @(posedge clk) begin
        if (bus.mem_wr_en) wr_count++;
        if (bus.done)      done_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.cpu_addr   = a;
        bus.cpu_dat_in = d;
        bus.cpu_wr_en  = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_wr_en  = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        bus.cpu_addr = a;
        @(negedge clk);
        d = bus.cpu_dat_out;
        @(posedge clk);
        #1;
    endtask

    // Bytes are packed little-first: word[7:0] goes to base.
    task automatic load(input logic [7:0] base, input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) cpu_write(base + 8'(i), word[8*i +: 8]);
    endtask

    task automatic expect_bytes(input string tag, input logic [7:0] base,
                                input logic [31:0] word, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            cpu_read(base + 8'(i), d);
            check($sformatf("%s[%0d]", tag, i), {24'h0, d}, {24'h0, word[8*i +: 8]});
        end
    endtask

    // Counts falling edges after the start edge until done; returns in the IDLE cycle after done.
    task automatic wait_done(input string tag, input int max, output int cyc);
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
        end
        check({tag, "_done_seen"}, {31'h0, bus.done}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_move(input string tag, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, output int cyc);
        bus.src   = s;
        bus.dst   = d;
        bus.len   = l;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(tag, 600, cyc);
    endtask

    logic [7:0] exp_fwd_sum;
    logic [7:0] rd;
    int cyc;
    int w0;
    int d0;

    initial begin
`ifdef DMOVE_CHECKSUM_EN
        exp_fwd_sum = 8'h04;
`else
        exp_fwd_sum = 8'h00;
`endif
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.src        = '0;
        bus.dst        = '0;
        bus.len        = '0;
        bus.cpu_addr   = '0;
        bus.cpu_wr_en  = 1'b0;
        bus.cpu_dat_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_sum",  {24'h0, bus.checksum}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Forward move with latency, single done pulse and checksum.
        load(8'h10, 32'hD4C3B2A1, 4);
        w0 = wr_count;
        d0 = done_count;
        run_move("fwd", 8'h10, 8'h40, 8'd4, cyc);
        check("fwd_cycles", cyc, 9);
        check("fwd_writes", wr_count - w0, 4);
        check("fwd_done_pulses", done_count - d0, 1);
        check("fwd_done_low", {31'h0, bus.done}, 32'h0);
        check("fwd_sum", {24'h0, bus.checksum}, {24'h0, exp_fwd_sum});
        expect_bytes("fwd", 8'h40, 32'hD4C3B2A1, 4);

        // Overlap, destination above source: must copy backward.
        load(8'h20, 32'h04030201, 4);
        run_move("bwd", 8'h20, 8'h22, 8'd4, cyc);
        expect_bytes("bwd", 8'h22, 32'h04030201, 4);
        expect_bytes("bwd_head", 8'h20, 32'h00000201, 2);

        // Overlap, destination below source: forward is safe.
        load(8'h22, 32'h04030201, 4);
        run_move("ovf", 8'h22, 8'h20, 8'd4, cyc);
        expect_bytes("ovf", 8'h20, 32'h04030201, 4);

        // Source crosses 0xFF -> 0x00.
        load(8'hFE, 32'h0000AA55, 2);
        run_move("wrap", 8'hFE, 8'h01, 8'd2, cyc);
        check("wrap_cycles", cyc, 5);
        expect_bytes("wrap", 8'h01, 32'h0000AA55, 2);

        // src == dst rewrites each byte with itself.
        load(8'h30, 32'h00006655, 2);
        w0 = wr_count;
        run_move("same", 8'h30, 8'h30, 8'd2, cyc);
        check("same_writes", wr_count - w0, 2);
        expect_bytes("same", 8'h30, 32'h00006655, 2);

        // Zero length: done next cycle, no writes, checksum cleared.
        w0 = wr_count;
        run_move("len0", 8'h50, 8'h60, 8'd0, cyc);
        check("len0_cycles", cyc, 1);
        check("len0_writes", wr_count - w0, 0);
        check("len0_sum", {24'h0, bus.checksum}, 32'h0);

        // Processor write during a move is dropped; reads follow the engine address.
        cpu_write(8'h80, 8'h00);
        bus.src   = 8'h10;
        bus.dst   = 8'h48;
        bus.len   = 8'd4;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.cpu_addr   = 8'h80;
        bus.cpu_dat_in = 8'h5A;
        bus.cpu_wr_en  = 1'b1;
        @(negedge clk);
        check("busy_flag", {31'h0, bus.busy}, 32'h1);
        check("busy_read", {24'h0, bus.cpu_dat_out}, 32'hA1);
        repeat (3) @(posedge clk);
        #1;
        bus.cpu_wr_en = 1'b0;
        wait_done("cpu", 600, cyc);
        cpu_read(8'h80, rd);
        check("busy_wr_dropped", {24'h0, rd}, 32'h00);
        expect_bytes("cpu_mv", 8'h48, 32'hD4C3B2A1, 4);
        cpu_write(8'h80, 8'h5A);
        cpu_read(8'h80, rd);
        check("idle_wr_lands", {24'h0, rd}, 32'h5A);

        // Reset after two bytes of a four-byte move; start held with reset must lose.
        load(8'h60, 32'h44332211, 4);
        load(8'h70, 32'h00000000, 4);
        d0 = done_count;
        bus.src   = 8'h60;
        bus.dst   = 8'h70;
        bus.len   = 8'd4;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("mid_rst_done", {31'h0, bus.done}, 32'h0);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_count - d0, 0);
        expect_bytes("mid_rst", 8'h70, 32'h00002211, 4);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/dat_mem_mover.md
# dat_mem_mover

Block-move engine sitting directly upstream of the 256×8 data memory. It owns the memory's single address/write port. When idle it passes the processor's load/store traffic straight through. When started, it copies `len` bytes from `src` to `dst` inside data memory with memmove semantics, so overlapping regions are copied correctly. It then pulses `done`.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width; 256-byte space.
- `DATA_W`, 8: memory word width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a move; sampled only in IDLE.
- `src`  in  8: source base address.
- `dst`  in  8: destination base address.
- `len`  in  8: byte count; 0 means no bytes are moved.
- `cpu_addr`  in  8: processor address.
- `cpu_wr_en`  in  1: processor write enable.
- `cpu_dat_in`  in  8: processor write data.
- `cpu_dat_out`  out  8: processor read data; always equals `mem_dat_out`.
- `mem_addr`  out  8: address to data memory.
- `mem_wr_en`  out  1: write enable to data memory.
- `mem_dat_in`  out  8: write data to data memory.
- `mem_dat_out`  in  8: combinational read data from data memory.
- `busy`  out  1: high in READ and WRITE.
- `done`  out  1: one-cycle pulse at end of a move.
- `checksum`  out  8: XOR of all bytes moved (see Configuration).

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Memory port is muxed to the processor: `mem_addr=cpu_addr`, `mem_wr_en=cpu_wr_en`, `mem_dat_in=cpu_dat_in`.
  - On `start=1`, latch `src`, `dst`, `len` and compute direction.
  - If `len==0`, go to DONE; otherwise go to READ.
- Direction rule:
  - Compute `diff = dst - src` (8-bit, mod 256).
  - If `diff != 0` and `diff < len`, copy backward. Pointers start at `src+len-1` and `dst+len-1` (mod 256) and decrement.
  - Otherwise copy forward from `src` and `dst`, incrementing.
- READ:
  - `mem_addr = src_ptr`, `mem_wr_en = 0`.
  - `mem_dat_out` is captured into the data register at the clock edge.
  - Go to WRITE.
- WRITE:
  - `mem_addr = dst_ptr`, `mem_wr_en = 1`, `mem_dat_in = data register`.
  - Step both pointers and decrement the remaining count.
  - If remaining becomes 0, go to DONE; otherwise go to READ.
- DONE:
  - Assert `done` for exactly one cycle, then go to IDLE.
  - Memory port is muxed to the processor in this state.
- Processor accesses while `busy=1`:
  - Writes are dropped (`cpu_wr_en` is ignored).
  - Reads return the byte at the engine's current address.
- `start` while not in IDLE is ignored.
- Pointers wrap modulo 256; a move that crosses 0xFF→0x00 is legal.
- `src==dst`: forward copy; each byte is rewritten with its own value.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `checksum=0x00`, pointers/count/data register = 0.
- Latency: `start` accepted at edge N; for `len=L>0`, `done` is high in the cycle after edge N+2L. That is 2L+1 cycles from the start edge to `done`.
- `len=0`: `done` is high in the cycle after the start edge; no memory writes occur.
- Throughput: one byte per 2 cycles.
- Reset mid-move: at the next edge the engine returns to IDLE. No further engine writes occur, bytes already written remain, and `done` is not pulsed.
- Reset and `start` asserted together: reset wins.

## Configuration
- `DMOVE_CHECKSUM_EN` defined:
  - `checksum` is cleared when `start` is accepted.
  - It XOR-accumulates each byte at its WRITE cycle.
  - It holds the final value from DONE until the next accepted start.
- Not defined: `checksum` is constant 0x00 and no accumulator register is generated.

## Structure
- Shared package `dmove_pkg`:
  - `ADDR_W`/`DATA_W` constants.
  - `dmove_state_t` enum {IDLE, READ, WRITE, DONE}.
- Flat single module; no sub-module is needed.
- Instantiated beside `dat_mem`: its `mem_*` outputs drive `dat_mem`'s `addr`/`wr_en`/`dat_in`, and `dat_mem`'s `dat_out` feeds back into `mem_dat_out`.

## Test plan
- Forward move: preload [0x10..0x13]=A1,B2,C3,D4; start src=0x10, dst=0x40, len=4 → [0x40..0x43]=A1,B2,C3,D4; `done` 9 cycles after the start edge; checksum=0xA1^0xB2^0xC3^0xD4=0x04 (with macro).
- Overlap backward: [0x20..0x23]=01,02,03,04; src=0x20, dst=0x22, len=4 → [0x22..0x25]=01,02,03,04.
- Overlap forward: [0x22..0x25]=01,02,03,04; src=0x22, dst=0x20, len=4 → [0x20..0x23]=01,02,03,04.
- Wrap: [0xFE,0xFF]=55,AA; src=0xFE, dst=0x01, len=2 → [0x01]=55, [0x02]=AA.
- `len=0` → `done` next cycle, no `mem_wr_en`. Processor write to 0x80 during a move → dropped; the same write while idle → lands.
- Reset asserted after 2 bytes of a len=4 move → IDLE, `busy=0`, no `done` pulse; only the first 2 destination bytes are changed.
